sparc_ifu_missreq_sched: RTL and testbench
==========================================

Name: sparc_ifu_missreq_sched

Overview:
- Per-thread I-cache miss request scheduler for the four IFU threads.
- Tracks each thread's miss through a small per-thread FSM.
- Arbitrates pending misses onto a single L2 request port using least-recently-granted priority, and caps the number of outstanding misses.
- Sits between the IFU miss detect logic and the PCX request interface; retires misses on fill return.

Parameters:
MAX_OUT, 2, maximum number of threads allowed in ISSUED state simultaneously (legal values 1-4).
TMO_W, 8, width of the per-thread fill timeout counter; timeout fires at count 2^TMO_W-1.

Ports:
clk  input  1  core clock.
reset  input  1  asynchronous, active-high reset.
miss_req  input  4  one-cycle pulse per thread: new I-cache miss.
miss_kill  input  4  one-cycle pulse per thread: cancel that thread's miss (flush or redirect).
pcx_req  output  1  registered request valid to the L2 port.
pcx_tid  output  2  registered thread id of the presented request.
pcx_gnt  input  1  port accepts the presented request this cycle.
fill_vld  input  1  fill return valid.
fill_tid  input  2  thread id of the fill.
thr_wait  output  4  thread has a miss in PEND or ISSUED.
fill_drop  output  1  registered; pulses the cycle after a fill that returns for a discarded miss.
out_cnt  output  3  number of threads currently in ISSUED.
tmo_err  output  4  sticky per-thread fill timeout flag.

Behaviour:
- Reset (async): all threads IDLE, discard flags 0, counters 0, pcx_req=0, pcx_tid=0, fill_drop=0, out_cnt=0, tmo_err=0. Priority order from MRU to LRU is T0,T1,T2,T3, so T3 wins first.
- Handshake: hs = pcx_req & pcx_gnt.
- Per-thread FSM states: IDLE, PEND, ISSUED.
  - IDLE -> PEND on miss_req[t].
  - PEND -> IDLE on miss_kill[t], unless t is currently presented (pcx_req & pcx_tid==t). In that case the kill is held as pending-discard.
  - PEND -> ISSUED on hs & pcx_tid==t. The discard flag is set if a held kill exists or miss_kill[t] arrives in the same cycle.
  - ISSUED + miss_kill[t]: set the discard flag; the state is unchanged because the fill must still be absorbed.
  - ISSUED -> IDLE on fill_vld & fill_tid==t. If miss_req[t] arrives in the same cycle, go to PEND instead, with discard cleared.
  - miss_req[t] in PEND, or in ISSUED without a coincident fill: ignored.
  - Fill for a thread not in ISSUED: ignored, no state change.
- fill_drop = 1 in the cycle after a fill retires an ISSUED thread whose discard flag = 1.
- Arbitration, evaluated every cycle:
  - Candidates are PEND threads, excluding a thread being handshaken this cycle and excluding a PEND thread killed this cycle.
  - Eligibility requires (out_cnt + hs_this_cycle - fills_retiring_this_cycle) < MAX_OUT.
  - The winner is the LRU candidate. The result is registered into pcx_req/pcx_tid.
  - Back-to-back presentation is allowed: a new request can appear the cycle after a handshake.
- Hold rule: while pcx_req=1 and pcx_gnt=0, pcx_req and pcx_tid stay stable. No re-arbitration occurs, including on kill of the presented thread.
- Priority update: on hs only, the granted thread moves to MRU and the threads ahead of it shift down one place. The order is unchanged when there is no handshake.
- Latency:
  - miss_req at cycle N gives PEND at N+1 and pcx_req at N+2 (idle port, below the cap).
  - Fill at cycle M makes that thread IDLE at M+1.
- out_cnt: +1 on hs, -1 on a fill that retires an ISSUED thread. A simultaneous +1/-1 nets to 0. It never exceeds MAX_OUT.
- Timeout:
  - Each thread's counter clears on entry to ISSUED and increments every cycle in ISSUED, saturating.
  - At all-ones, tmo_err[t] is set. It is sticky until reset and has no effect on the FSM.
- thr_wait[t] = state != IDLE (registered state decode).

Test Plan:
- Reset release; miss_req=4'b1111 at N; pcx_gnt held 1 -> pcx_tid sequence 3,2,1,0 starting N+2, one per cycle while below the cap. With MAX_OUT=2, only 3 and 2 issue; out_cnt=2 and pcx_req=0 until a fill.
- Hold rule: T1 presented, pcx_gnt=0 for 5 cycles, miss_req[3] arrives -> pcx_tid stays 1. On gnt, T1 goes ISSUED and T3 is presented the next cycle.
- miss_kill[2] while T2 is PEND and not presented -> T2 IDLE, thr_wait[2]=0, never issued. Kill while presented -> issued with discard; its fill gives fill_drop=1 one cycle later and out_cnt decrements.
- Fill for T0 coincident with miss_req[0] and with hs for T1 -> T0 PEND, T1 ISSUED, out_cnt unchanged. T0 is presented only after the LRU threads ahead of it.
- T2 ISSUED with no fill for 255 cycles (TMO_W=8) -> tmo_err=4'b0100 stays set. A later fill retires T2, but tmo_err stays set until reset.
- Assert reset mid-operation with pcx_req=1 -> outputs 0 immediately (async), all threads IDLE. The first grant after release goes to T3.

Source files
------------

// File: rtl/sparc_ifu_missreq_sched.sv
// I-cache miss request scheduler for the four IFU threads.
// Each thread walks IDLE -> PEND -> ISSUED -> IDLE. Pending misses compete
// for the single L2 request port under least-recently-granted priority, and
// the number of outstanding (ISSUED) misses is capped at MAX_OUT.
//
//   state  | meaning
//   IDLE   | no miss outstanding for this thread
//   PEND   | miss detected, waiting to be granted on the L2 port
//   ISSUED | request accepted by L2, waiting for the fill to return
module sparc_ifu_missreq_sched #(
    parameter int MAX_OUT = 2,
    parameter int TMO_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] miss_req,
    input  logic [3:0] miss_kill,
    output logic       pcx_req,
    output logic [1:0] pcx_tid,
    input  logic       pcx_gnt,
    input  logic       fill_vld,
    input  logic [1:0] fill_tid,
    output logic [3:0] thr_wait,
    output logic       fill_drop,
    output logic [2:0] out_cnt,
    output logic [3:0] tmo_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PEND   = 2'd1,
        S_ISSUED = 2'd2
    } thr_state_t;

    // Value one below all-ones: the counter reaches saturation on the edge
    // where it leaves this value, and the sticky flag is raised on that edge.
    localparam logic [TMO_W-1:0] TMO_PRE = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

    thr_state_t       state [4];
    logic [3:0]       disc;
    logic [3:0]       khold;
    logic [TMO_W-1:0] tmo_cnt [4];
    logic [1:0]       ord [4];   // ord[0] = MRU ... ord[3] = LRU

    logic       hs;
    logic [3:0] tid_oh;
    logic [3:0] presented;
    logic [3:0] fill_ret;
    logic [3:0] cand;
    logic       fill_any;
    logic [3:0] cnt_eff;
    logic       cap_ok;
    logic       win_vld;
    logic [1:0] win_tid;
    logic [1:0] gpos;
    logic [1:0] ord_nxt [4];

    assign hs = pcx_req & pcx_gnt;

    // Per-thread decode of handshake, presentation, fill retirement and candidacy.
    always_comb begin
        tid_oh    = 4'b0;
        presented = 4'b0;
        fill_ret  = 4'b0;
        cand      = 4'b0;
        thr_wait  = 4'b0;
        for (int t = 0; t < 4; t++) begin
            tid_oh[t]    = (pcx_tid == 2'(t));
            presented[t] = pcx_req & tid_oh[t];
            fill_ret[t]  = fill_vld & (fill_tid == 2'(t)) & (state[t] == S_ISSUED);
            cand[t]      = (state[t] == S_PEND) & ~(hs & tid_oh[t]) & ~miss_kill[t];
            thr_wait[t]  = (state[t] != S_IDLE);
        end
    end

    assign fill_any = |fill_ret;

    // Outstanding count as it will stand after this edge decides eligibility.
    always_comb begin
        cnt_eff = {1'b0, out_cnt} + {3'b0, hs} - {3'b0, fill_any};
        cap_ok  = (cnt_eff < 4'(MAX_OUT));
    end

    // Pick the candidate furthest toward LRU; later positions overwrite earlier.
    always_comb begin
        win_vld = 1'b0;
        win_tid = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (cand[ord[i]]) begin
                win_vld = 1'b1;
                win_tid = ord[i];
            end
        end
    end

    // On a handshake the granted thread moves to MRU; those ahead shift down.
    always_comb begin
        gpos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (ord[i] == pcx_tid) gpos = 2'(i);
        end
        for (int i = 0; i < 4; i++) ord_nxt[i] = ord[i];
        if (hs) begin
            ord_nxt[0] = pcx_tid;
            for (int i = 1; i < 4; i++) begin
                if (2'(i) <= gpos) ord_nxt[i] = ord[i-1];
            end
        end
    end

    // Per-thread miss FSM, discard tracking and fill timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disc    <= 4'b0;
            khold   <= 4'b0;
            tmo_err <= 4'b0;
            for (int t = 0; t < 4; t++) begin
                state[t]   <= S_IDLE;
                tmo_cnt[t] <= '0;
            end
        end else begin
            for (int t = 0; t < 4; t++) begin
                case (state[t])
                    S_IDLE: begin
                        disc[t]  <= 1'b0;
                        khold[t] <= 1'b0;
                        if (miss_req[t]) state[t] <= S_PEND;
                    end
                    S_PEND: begin
                        if (hs && tid_oh[t]) begin
                            state[t]   <= S_ISSUED;
                            disc[t]    <= khold[t] | miss_kill[t];
                            khold[t]   <= 1'b0;
                            tmo_cnt[t] <= '0;
                        end else if (miss_kill[t]) begin
                            // A presented request cannot be withdrawn, so the kill
                            // is remembered and applied once it is granted.
                            if (presented[t]) begin
                                khold[t] <= 1'b1;
                            end else begin
                                state[t] <= S_IDLE;
                                khold[t] <= 1'b0;
                            end
                        end
                    end
                    S_ISSUED: begin
                        if (fill_ret[t]) begin
                            state[t] <= miss_req[t] ? S_PEND : S_IDLE;
                            disc[t]  <= 1'b0;
                        end else begin
                            if (miss_kill[t]) disc[t] <= 1'b1;
                            if (tmo_cnt[t] != TMO_MAX) tmo_cnt[t] <= tmo_cnt[t] + 1'b1;
                            if (tmo_cnt[t] == TMO_PRE) tmo_err[t] <= 1'b1;
                        end
                    end
                    default: state[t] <= S_IDLE;
                endcase
            end
        end
    end

    // Request port, outstanding count, drop pulse and priority order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcx_req   <= 1'b0;
            pcx_tid   <= 2'd0;
            fill_drop <= 1'b0;
            out_cnt   <= 3'd0;
            for (int i = 0; i < 4; i++) ord[i] <= 2'(i);
        end else begin
            fill_drop <= |(fill_ret & disc);
            out_cnt   <= cnt_eff[2:0];
            for (int i = 0; i < 4; i++) ord[i] <= ord_nxt[i];
            if (!(pcx_req && !pcx_gnt)) begin
                pcx_req <= win_vld & cap_ok;
                pcx_tid <= win_tid;
            end
        end
    end

endmodule

// File: tb/tb_sparc_ifu_missreq_sched.sv
// Scenario bench for the IFU miss request scheduler (MAX_OUT=2, TMO_W=8).
// Expected grant order is queued as each scenario is driven; a negedge
// monitor pops and compares whenever a handshake is on the port.
module tb_sparc_ifu_missreq_sched;

    logic       clk;
    logic       reset;
    logic [3:0] miss_req;
    logic [3:0] miss_kill;
    logic       pcx_req;
    logic [1:0] pcx_tid;
    logic       pcx_gnt;
    logic       fill_vld;
    logic [1:0] fill_tid;
    logic [3:0] thr_wait;
    logic       fill_drop;
    logic [2:0] out_cnt;
    logic [3:0] tmo_err;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    sparc_ifu_missreq_sched #(.MAX_OUT(2), .TMO_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .miss_req  (miss_req),
        .miss_kill (miss_kill),
        .pcx_req   (pcx_req),
        .pcx_tid   (pcx_tid),
        .pcx_gnt   (pcx_gnt),
        .fill_vld  (fill_vld),
        .fill_tid  (fill_tid),
        .thr_wait  (thr_wait),
        .fill_drop (fill_drop),
        .out_cnt   (out_cnt),
        .tmo_err   (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        chk("q_drained", exp_q.size(), 0);
        exp_q.delete();
        reset     = 1'b1;
        miss_req  = 4'b0;
        miss_kill = 4'b0;
        pcx_gnt   = 1'b0;
        fill_vld  = 1'b0;
        fill_tid  = 2'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic fill(input logic [1:0] tid);
        fill_vld = 1'b1;
        fill_tid = tid;
        step();
        fill_vld = 1'b0;
    endtask

    // Scoreboard: every handshake must match the next expected grant.
    always @(negedge clk) begin
        if (!reset && pcx_req && pcx_gnt) begin
            if (exp_q.size() == 0) chk("gnt_unexpected", int'(pcx_tid), -1);
            else chk("gnt_tid", int'(pcx_tid), exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        miss_req = 4'b0; miss_kill = 4'b0; pcx_gnt = 1'b0;
        fill_vld = 1'b0; fill_tid = 2'd0;
        #2;
        chk("rst_req", int'(pcx_req), 0);
        chk("rst_tid", int'(pcx_tid), 0);
        chk("rst_wait", int'(thr_wait), 0);
        chk("rst_cnt", int'(out_cnt), 0);
        chk("rst_tmo", int'(tmo_err), 0);
        chk("rst_drop", int'(fill_drop), 0);
        reset_dut();

        // All four miss at once with grant held: T3 then T2, then the cap bites.
        pcx_gnt = 1'b1;
        exp_q.push_back(3);
        exp_q.push_back(2);
        miss_req = 4'b1111;
        step();
        miss_req = 4'b0;
        chk("lat_pend_req", int'(pcx_req), 0);
        chk("lat_pend_wait", int'(thr_wait), 15);
        step();
        chk("burst_req0", int'(pcx_req), 1);
        chk("burst_tid0", int'(pcx_tid), 3);
        step();
        chk("burst_tid1", int'(pcx_tid), 2);
        step();
        chk("cap_req", int'(pcx_req), 0);
        chk("cap_cnt", int'(out_cnt), 2);
        step();
        step();
        chk("cap_req_hold", int'(pcx_req), 0);
        chk("cap_cnt_hold", int'(out_cnt), 2);
        reset_dut();

        // Hold rule: T1 presented without grant, T3 arrives meanwhile.
        miss_req = 4'b0010;
        step();
        miss_req = 4'b0;
        step();
        chk("hold_req", int'(pcx_req), 1);
        chk("hold_tid", int'(pcx_tid), 1);
        miss_req = 4'b1000;
        step();
        miss_req = 4'b0;
        for (int i = 0; i < 4; i++) begin
            chk("hold_tid_stable", int'(pcx_tid), 1);
            step();
        end
        chk("hold_req_stable", int'(pcx_req), 1);
        pcx_gnt = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(3);
        step();
        chk("b2b_req", int'(pcx_req), 1);
        chk("b2b_tid", int'(pcx_tid), 3);
        chk("b2b_cnt", int'(out_cnt), 1);
        step();
        pcx_gnt = 1'b0;
        chk("b2b_cnt2", int'(out_cnt), 2);
        fill(2'd1);
        chk("clean_drop", int'(fill_drop), 0);
        chk("clean_cnt", int'(out_cnt), 1);
        chk("clean_wait", int'(thr_wait), 8);
        reset_dut();

        // Kills: T2 killed while pending only, T3 killed while presented.
        miss_req = 4'b1100;
        step();
        miss_req = 4'b0;
        step();
        chk("kill_pres_tid", int'(pcx_tid), 3);
        miss_kill = 4'b0100;
        step();
        miss_kill = 4'b0;
        chk("kill_pend_wait", int'(thr_wait), 8);
        miss_kill = 4'b1000;
        step();
        miss_kill = 4'b0;
        chk("kill_held_wait", int'(thr_wait), 8);
        chk("kill_held_tid", int'(pcx_tid), 3);
        pcx_gnt = 1'b1;
        exp_q.push_back(3);
        step();
        pcx_gnt = 1'b0;
        chk("kill_iss_cnt", int'(out_cnt), 1);
        chk("kill_iss_req", int'(pcx_req), 0);
        fill(2'd3);
        chk("drop_pulse", int'(fill_drop), 1);
        chk("drop_cnt", int'(out_cnt), 0);
        chk("drop_wait", int'(thr_wait), 0);
        step();
        chk("drop_clear", int'(fill_drop), 0);
        reset_dut();

        // Fill + re-miss on T0 coincident with the T1 handshake.
        miss_req = 4'b0001;
        step();
        miss_req = 4'b0;
        step();
        pcx_gnt = 1'b1;
        exp_q.push_back(0);
        step();
        pcx_gnt = 1'b0;
        chk("co_t0_cnt", int'(out_cnt), 1);
        miss_req = 4'b0010;
        step();
        miss_req = 4'b0;
        step();
        chk("co_t1_tid", int'(pcx_tid), 1);
        miss_req = 4'b1100;
        step();
        miss_req = 4'b0;
        fill_vld = 1'b1; fill_tid = 2'd0; miss_req = 4'b0001; pcx_gnt = 1'b1;
        exp_q.push_back(1);
        step();
        fill_vld = 1'b0; miss_req = 4'b0; pcx_gnt = 1'b0;
        chk("co_wait", int'(thr_wait), 15);
        chk("co_cnt", int'(out_cnt), 1);
        chk("co_next_tid", int'(pcx_tid), 3);
        pcx_gnt = 1'b1;
        exp_q.push_back(3);
        step();
        pcx_gnt = 1'b0;
        chk("co_cap_req", int'(pcx_req), 0);
        fill(2'd1);
        chk("co_lru_tid2", int'(pcx_tid), 2);
        pcx_gnt = 1'b1;
        exp_q.push_back(2);
        step();
        pcx_gnt = 1'b0;
        fill(2'd3);
        chk("co_lru_tid0", int'(pcx_tid), 0);
        chk("co_lru_req0", int'(pcx_req), 1);
        pcx_gnt = 1'b1;
        exp_q.push_back(0);
        step();
        pcx_gnt = 1'b0;
        reset_dut();

        // Fill timeout on T2.
        miss_req = 4'b0100;
        step();
        miss_req = 4'b0;
        step();
        pcx_gnt = 1'b1;
        exp_q.push_back(2);
        step();
        pcx_gnt = 1'b0;
        repeat (254) step();
        chk("tmo_before", int'(tmo_err), 0);
        step();
        chk("tmo_set", int'(tmo_err), 4);
        repeat (20) step();
        fill(2'd2);
        step();
        chk("tmo_sticky", int'(tmo_err), 4);
        chk("tmo_retired", int'(thr_wait), 0);
        reset_dut();
        chk("tmo_cleared", int'(tmo_err), 0);

        // Asynchronous reset while a request is presented.
        miss_req = 4'b1000;
        step();
        miss_req = 4'b0;
        step();
        chk("async_pre_req", int'(pcx_req), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_req", int'(pcx_req), 0);
        chk("async_tid", int'(pcx_tid), 0);
        chk("async_wait", int'(thr_wait), 0);
        step();
        reset = 1'b0;
        miss_req = 4'b1111;
        step();
        miss_req = 4'b0;
        step();
        chk("post_rst_tid", int'(pcx_tid), 3);
        pcx_gnt = 1'b1;
        exp_q.push_back(3);
        exp_q.push_back(2);
        step();
        step();
        pcx_gnt = 1'b0;
        chk("post_rst_cnt", int'(out_cnt), 2);
        step();

        chk("q_final", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
